key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 50_000_000: cycles the key must stay pressed after the first press pulse to report a hold.
REQ-002 The block SHALL have parameter GAP_CYC, default 15_000_000: cycles after release within which a second press counts as a double press.
REQ-003 The block SHALL have parameter REPEAT_CYC, default 10_000_000: hold-repeat period, used only when KEY_REPEAT_EN is defined.
REQ-004 Clock  input  1  single clock, all logic on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Pulse  input  1  one-cycle debounced press pulse from the key filter.
REQ-007 Level  input  1  synchronized raw key level, 1 = pressed.
REQ-008 Single  output  1  one-cycle pulse: single press completed.
REQ-009 Double  output  1  one-cycle pulse: double press detected.
REQ-010 Hold  output  1  one-cycle pulse: long hold detected (and repeats when enabled).
REQ-011 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 States SHALL be IDLE, PRESS1, WAIT, PRESS2 and HELD, with one internal 32-bit cycle timer.
REQ-013 IDLE: Pulse=1 SHALL move to PRESS1 and clear the timer; all other inputs SHALL be ignored.
REQ-014 PRESS1: if Level=1 the timer SHALL increment; when it reaches HOLD_CYC-1 with Level=1, the block SHALL pulse Hold and move to HELD.
REQ-015 PRESS1: Level=0 SHALL move to WAIT and clear the timer, with no event output.
REQ-016 WAIT: Pulse=1 SHALL pulse Double and move to PRESS2.
REQ-017 WAIT: otherwise the timer SHALL increment, and at GAP_CYC-1 the block SHALL pulse Single and move to IDLE.
REQ-018 WAIT: Pulse=1 on the timer's terminal cycle SHALL take priority (Double, not Single).
REQ-019 PRESS2 and HELD: Level=0 SHALL move to IDLE; a second press SHALL never report Hold.
REQ-020 Pulse SHALL be ignored in PRESS1, PRESS2 and HELD, so filter repeat pulses during a held key have no effect.
REQ-021 Single, Double and Hold SHALL be registered and assert exactly one cycle, in the cycle after the qualifying input edge.
REQ-022 At most one of Single, Double and Hold SHALL be high in any cycle.
REQ-023 Busy SHALL be decoded from the state register, with no extra latency.
REQ-024 The timer SHALL saturate and never wrap; HOLD_CYC and GAP_CYC SHALL each be >= 2.

Reset
REQ-025 Reset=1 SHALL force IDLE, timer=0, and Single=Double=Hold=Busy=0 on the next edge, overriding all inputs.
REQ-026 Reset asserted mid-sequence SHALL drop the sequence with no event output, and no event SHALL be emitted in the cycle after release.

Configuration
REQ-027 Macro KEY_REPEAT_EN defined: in HELD with Level=1, the timer SHALL count and Hold SHALL pulse every REPEAT_CYC cycles after entering HELD until release.
REQ-028 Macro KEY_REPEAT_EN undefined: HELD SHALL emit nothing and only wait for Level=0, and the repeat logic SHALL not be synthesized.

Verification (HOLD_CYC=8, GAP_CYC=6, REPEAT_CYC=4)
REQ-029 Single press: Pulse at cycle 0, Level high for cycles 0-2, then low -> Single for exactly one cycle 6 cycles after the release edge; Busy then 0.
REQ-030 Double press: press/release, then Pulse 3 cycles after release -> Double once, then IDLE after the second release; Single never asserts.
REQ-031 Gap boundary: second Pulse on the terminal WAIT cycle -> Double; Pulse one cycle later -> Single, and that Pulse starts a new PRESS1.
REQ-032 Hold: Pulse then Level high for 20 cycles -> Hold 8 cycles after the Pulse; extra Pulses during the hold are ignored. With KEY_REPEAT_EN, Hold also pulses every 4 cycles; without it, exactly one Hold.
REQ-033 Reset asserted in WAIT at timer=3 -> no Single, Busy=0 on the next cycle, and a subsequent fresh press behaves normally.

Source files
------------

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key press pulses into single, double and hold events.
// Define KEY_REPEAT_EN to make a held key re-issue Hold every REPEAT_CYC cycles.
module key_event_decoder #(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned GAP_CYC    = 15_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Pulse,
  input  logic Level,
  output logic Single,
  output logic Double,
  output logic Hold,
  output logic Busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT, PRESS2, HELD} state_t;
  state_t state, state_nxt;
  logic [31:0] timer, timer_nxt, timer_inc;
  logic single_nxt, double_nxt, hold_nxt;
  if ((HOLD_CYC < 2) || (GAP_CYC < 2) || (REPEAT_CYC < 1)) begin : g_bad_param
    $error("key_event_decoder: HOLD_CYC and GAP_CYC must be >= 2, REPEAT_CYC >= 1");
  end
  assign timer_inc = &timer ? timer : timer + 32'd1;
  assign Busy = state != IDLE;
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    hold_nxt   = 1'b0;
    case (state)
      IDLE: if (Pulse) begin
        state_nxt = PRESS1;
        timer_nxt = '0;
      end
      PRESS1: if (!Level) begin
        state_nxt = WAIT;
        timer_nxt = '0;
      end else if (timer_inc == HOLD_CYC - 1) begin
        hold_nxt  = 1'b1;
        state_nxt = HELD;
        timer_nxt = '0;
      end else timer_nxt = timer_inc;
      // a press landing on the terminal gap cycle still wins over the timeout
      WAIT: if (Pulse) begin
        double_nxt = 1'b1;
        state_nxt  = PRESS2;
      end else if (timer_inc == GAP_CYC - 1) begin
        single_nxt = 1'b1;
        state_nxt  = IDLE;
        timer_nxt  = '0;
      end else timer_nxt = timer_inc;
      PRESS2: if (!Level) state_nxt = IDLE;
      HELD: if (!Level) begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
`ifdef KEY_REPEAT_EN
      else if (timer == REPEAT_CYC - 1) begin
        hold_nxt  = 1'b1;
        timer_nxt = '0;
      end else timer_nxt = timer_inc;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      timer  <= '0;
      Single <= 1'b0;
      Double <= 1'b0;
      Hold   <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      Single <= single_nxt;
      Double <= double_nxt;
      Hold   <= hold_nxt;
    end
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed scenarios for key_event_decoder with HOLD_CYC=8, GAP_CYC=6, REPEAT_CYC=4.
module tb_key_event_decoder;
  logic Clock = 1'b0, Reset = 1'b1, Pulse = 1'b0, Level = 1'b0;
  logic Single, Double, Hold, Busy;
  int vectors = 0, miscompares = 0;
  int ns, nd, nh, fs, fd, fh, ls, multi;
  logic [31:0] bz;
  always #5 Clock = ~Clock;
  key_event_decoder #(.HOLD_CYC(8), .GAP_CYC(6), .REPEAT_CYC(4)) dut (
    .Clock(Clock), .Reset(Reset), .Pulse(Pulse), .Level(Level),
    .Single(Single), .Double(Double), .Hold(Hold), .Busy(Busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // cycle c: inputs pm/lm/rm bit c applied, outputs of cycle c recorded
  task automatic run(input logic [31:0] pm, input logic [31:0] lm, input logic [31:0] rm, input int n);
    ns = 0; nd = 0; nh = 0; fs = -1; fd = -1; fh = -1; ls = -1; multi = 0; bz = '0;
    for (int c = 0; c < n; c++) begin
      Pulse = pm[c]; Level = lm[c]; Reset = rm[c];
      bz[c] = Busy;
      if (Single) begin if (fs < 0) fs = c; ls = c; ns++; end
      if (Double) begin if (fd < 0) fd = c; nd++; end
      if (Hold) begin if (fh < 0) fh = c; nh++; end
      if (int'(Single) + int'(Double) + int'(Hold) > 1) multi++;
      @(posedge Clock); #1;
    end
    Pulse = 1'b0; Level = 1'b0; Reset = 1'b0;
  endtask
  initial begin
    Pulse = 1'b1; Level = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy", 32'(Busy), 0);
    check("rst_events", {29'd0, Single, Double, Hold}, 0);
    Reset = 1'b0; Pulse = 1'b0; Level = 1'b0;
    @(posedge Clock); #1;
    check("post_rst_events", {29'd0, Single, Double, Hold, Busy}, 0);
    run(32'h1, 32'h7, 32'h0, 12);
    check("single_at", fs, 9);
    check("single_cnt", ns, 1);
    check("single_other", nd + nh, 0);
    check("single_busy", bz, 32'h1FE);
    run(32'h41, 32'h1C7, 32'h0, 16);
    check("double_at", fd, 7);
    check("double_cnt", nd, 1);
    check("double_nosingle", ns, 0);
    check("double_busy", bz, 32'h3FE);
    run(32'h101, 32'h307, 32'h0, 14);
    check("gap_term_double_at", fd, 9);
    check("gap_term_nosingle", ns, 0);
    run(32'h201, 32'h607, 32'h0, 20);
    check("gap_late_single_at", fs, 9);
    check("gap_late_nodouble", nd, 0);
    check("gap_late_single2_at", ls, 17);
    check("gap_late_cnt", ns, 2);
    check("gap_late_busy", bz, 32'h1FDFE);
    run(32'h8409, 32'hFFFFF, 32'h0, 24);
    check("hold_at", fh, 8);
`ifdef KEY_REPEAT_EN
    check("hold_cnt", nh, 4);
`else
    check("hold_cnt", nh, 1);
`endif
    check("hold_other", ns + nd, 0);
    check("hold_busy", bz, 32'h1FFFFE);
    run(32'h41, 32'h3FFFFC7, 32'h0, 30);
    check("press2_nohold", nh, 0);
    check("press2_double", nd, 1);
    check("press2_nosingle", ns, 0);
    run(32'h1, 32'h7, 32'h80, 14);
    check("rst_wait_nosingle", ns, 0);
    check("rst_wait_busy", bz, 32'hFE);
    run(32'h1, 32'h7, 32'h0, 12);
    check("after_rst_single_at", fs, 9);
    check("after_rst_cnt", ns, 1);
    check("onehot_last", multi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
